seq_det_piso: RTL and testbench
===============================

# seq_det_piso

Parallel-in/serial-out bit feeder that sits directly upstream of the 1010 sequence detector. It accepts WIDTH-bit words over a valid/ready handshake and emits one bit per clock on a registered serial output that drives the detector's `x` input. A one-word holding register lets back-to-back words stream with no idle bit between them.

## Interface
- `WIDTH`, default 8: word width in bits, must be at least 2.
- `MSB_FIRST`, default 1: 1 shifts `din[WIDTH-1]` first; 0 shifts `din[0]` first.
- `IDLE_BIT`, default 0: value driven on `x` when no word is being shifted.

- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst`  in  1: reset, asynchronous and active-low.
- `din`  in  WIDTH: parallel word; sampled on accept.
- `din_valid`  in  1: producer has a word on `din`.
- `din_ready`  out  1: block can take a word this cycle. Accept = `din_valid & din_ready` at the rising edge.
- `x`  out  1: registered serial bit; connects to the detector's `x`.
- `x_valid`  out  1: `x` carries a data bit this cycle.
- `word_done`  out  1: one-cycle pulse, high during the cycle the last bit of a word is on `x`.
- `busy`  out  1: `x_valid | hold_full`.

## Operation
- Storage:
  - shift register `sr` (WIDTH bits);
  - bit counter `cnt` (clog2(WIDTH) bits) counting WIDTH-1 down to 0;
  - holding register `hold` with flag `hold_full`.
- `din_ready = !hold_full`, forced 0 while `rst` is low.
- States:
  - IDLE (`x_valid=0`, `x=IDLE_BIT`).
  - SHIFT (`x_valid=1`, `x` = current bit of `sr`).
- IDLE:
  - Accept loads the word into `sr` and sets `cnt=WIDTH-1`.
  - Next cycle: SHIFT, with the first bit on `x`.
- SHIFT, `cnt>0`:
  - Each edge advances `sr` by one bit (left shift for MSB_FIRST=1, right otherwise) and decrements `cnt`.
  - An accept here writes `hold` and sets `hold_full`.
- SHIFT, `cnt==0` (last bit, `word_done=1`):
  - If `hold_full`: `hold` moves to `sr`, `cnt=WIDTH-1`, `hold_full` clears; stay in SHIFT.
  - Else, if an accept occurs this cycle: the word bypasses `hold` straight into `sr`; stay in SHIFT.
  - Else: go to IDLE.
- Accept with `hold_full` set cannot occur because `din_ready=0`.
- Sustained throughput is one word per WIDTH cycles, with no gap bits.
- `din` is ignored unless accepted. A word, once accepted, is always shifted out in full unless reset intervenes.

## Timing
- Reset (`rst` low, asynchronous):
  - `x=IDLE_BIT`, `x_valid=0`, `word_done=0`, `busy=0`, `din_ready=0`.
  - `hold_full=0`, state IDLE, `cnt=0`.
  - After `rst` deasserts, `din_ready=1` from the first edge onward.
- Reset mid-word: the remaining bits and any held word are discarded and no `word_done` is issued. `x` returns to IDLE_BIT immediately (asynchronously).
- Latency: a word accepted at edge N has its first bit on `x` from edge N to N+1 (visible the cycle after accept) and its last bit in cycle N+WIDTH-1 relative to that first-bit cycle.
- `din_ready` falls the cycle after a word enters `hold`. It rises the cycle after `hold` drains into `sr`.
- `word_done` is asserted only with `x_valid=1`; it is never asserted in IDLE.
- `x` is registered, so the detector sees a glitch-free input and its `out` is combinational on that registered bit.

## Test plan
- Reset then single word, WIDTH=8, MSB_FIRST=1, `din=8'hA5` accepted at cycle 0:
  - `x` = 1,0,1,0,0,1,0,1 on cycles 1–8 with `x_valid=1`;
  - `word_done` on cycle 8 only;
  - cycle 9: `x=0`, `x_valid=0`, `busy=0`.
- Back-to-back streaming, `din_valid` held with 8'hAA then 8'h0A:
  - 16 contiguous valid bits 10101010 00001010 on cycles 1–16;
  - `word_done` on cycles 8 and 16;
  - no gap cycle.
- Backpressure, three words presented continuously:
  - word0 accepted cycle 0, word1 accepted cycle 1 into `hold`;
  - `din_ready=0` cycles 2–8; word2 accepted cycle 9;
  - all 24 bits emitted in order on cycles 1–24.
- MSB_FIRST=0 with `din=8'h01`: `x`=1,0,0,0,0,0,0,0 on cycles 1–8.
- Reset mid-operation:
  - word 8'hFF accepted, word 8'h0F held, `rst` driven low during bit 3;
  - `x_valid`, `busy`, `din_ready` go 0 immediately; no `word_done`;
  - after release, first accepted word shifts cleanly from bit 0.
- Integration with the 1010 detector: stream 8'hAA, MSB first; detector `out` pulses high on bits 4, 6 and 8 (overlapping matches) and is low everywhere else.

Source files
------------

// File: rtl/seq_det_piso.sv
// seq_det_piso: parallel-in/serial-out bit feeder for the 1010 sequence
// detector. Words arrive on a valid/ready handshake and leave one bit per
// clock on a registered x, with a one-word holding register so that
// back-to-back words stream without a gap bit.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | nothing to shift; x = IDLE_BIT, x_valid = 0
// SHIFT | a word is on x; cnt = bits still to come after the current one
module seq_det_piso #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int            CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_adv;
  logic [WIDTH-1:0] hold;
  logic [CW-1:0]    cnt;
  logic             hold_full;
  logic             accept;

  // Bit of a word that goes onto x first.
  function automatic logic lead_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Ready is held low during reset so no word is taken while state is cleared.
  assign din_ready = rst & ~hold_full;
  assign accept    = din_valid & din_ready;
  assign busy      = x_valid | hold_full;

  // Shift register contents after the current bit has been consumed.
  always_comb begin
    sr_adv = MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
  end

  // Serialiser FSM; x, x_valid and word_done are computed for the next cycle
  // so that the detector sees clean register outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      sr        <= '0;
      hold      <= '0;
      cnt       <= '0;
      hold_full <= 1'b0;
      x         <= IDLE_BIT;
      x_valid   <= 1'b0;
      word_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          word_done <= 1'b0;
          if (accept) begin
            state   <= SHIFT;
            sr      <= din;
            cnt     <= LAST;
            x       <= lead_bit(din);
            x_valid <= 1'b1;
          end else begin
            x       <= IDLE_BIT;
            x_valid <= 1'b0;
          end
        end

        SHIFT: begin
          if (cnt != '0) begin
            sr        <= sr_adv;
            cnt       <= cnt - ONE;
            x         <= lead_bit(sr_adv);
            word_done <= (cnt == ONE);
            if (accept) begin
              hold      <= din;
              hold_full <= 1'b1;
            end
          end else if (hold_full) begin
            // Last bit on x and a word is waiting: continue without a gap.
            sr        <= hold;
            cnt       <= LAST;
            hold_full <= 1'b0;
            x         <= lead_bit(hold);
            word_done <= 1'b0;
          end else if (accept) begin
            // Word arrives exactly on the last bit: bypass the holding register.
            sr        <= din;
            cnt       <= LAST;
            x         <= lead_bit(din);
            word_done <= 1'b0;
          end else begin
            state     <= IDLE;
            x         <= IDLE_BIT;
            x_valid   <= 1'b0;
            word_done <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          x         <= IDLE_BIT;
          x_valid   <= 1'b0;
          word_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_det_piso.sv
// Bench for seq_det_piso: an MSB-first and an LSB-first instance share the
// stimulus; a queue-of-bits model predicts every output each cycle.
module tb_seq_det_piso;

  localparam int W    = 8;
  localparam bit IDLE = 1'b0;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;

  logic m_ready, m_x, m_xv, m_wd, m_busy;
  logic l_ready, l_x, l_xv, l_wd, l_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Each entry: {last_bit_of_word, bit}
  logic [1:0] q_m[$];
  logic [1:0] q_l[$];
  logic       exp_ready = 1'b0;
  logic [3:0] hist = '0;
  logic       last_det = 1'b0;

  seq_det_piso #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(IDLE)) u_msb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(m_ready), .x(m_x), .x_valid(m_xv), .word_done(m_wd), .busy(m_busy)
  );

  seq_det_piso #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(IDLE)) u_lsb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(l_ready), .x(l_x), .x_valid(l_xv), .word_done(l_wd), .busy(l_busy)
  );

  always #5 clk = ~clk;

  // Compare both DUTs against the model for the current cycle.
  task automatic sample_check();
    logic [1:0] e;
    logic       er, ev;
    logic [4:0] obs, req;
    er = rst && (q_m.size() <= W);
    ev = (q_m.size() > 0);
    e  = {1'b0, IDLE};
    if (ev) e = q_m.pop_front();
    req = {er, ev, ev, e[0], e[1]};
    obs = {m_ready, m_xv, m_busy, m_x, m_wd};
    checks++;
    if (obs !== req) begin
      errors++;
      $display("FAIL msb_outputs cyc %0d got %b want %b (ready,x_valid,busy,x,word_done)", cyc, obs, req);
    end
    if (ev) begin
      last_det = ({hist[2:0], m_x} == 4'b1010);
      hist     = {hist[2:0], m_x};
    end else begin
      last_det = 1'b0;
    end
    ev = (q_l.size() > 0);
    e  = {1'b0, IDLE};
    if (ev) e = q_l.pop_front();
    req = {er, ev, ev, e[0], e[1]};
    obs = {l_ready, l_xv, l_busy, l_x, l_wd};
    checks++;
    if (obs !== req) begin
      errors++;
      $display("FAIL lsb_outputs cyc %0d got %b want %b (ready,x_valid,busy,x,word_done)", cyc, obs, req);
    end
    exp_ready = er;
  endtask

  // Drive one cycle of handshake inputs, update the model, advance and check.
  task automatic tick(input logic v, input logic [W-1:0] d, output logic acc);
    din_valid = v;
    din       = d;
    acc       = v && exp_ready;
    if (acc) begin
      for (int i = 0; i < W; i++) begin
        q_m.push_back({(i == W - 1), d[W-1-i]});
        q_l.push_back({(i == W - 1), d[i]});
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    sample_check();
  endtask

  task automatic idle_ticks(input int n);
    logic a;
    for (int i = 0; i < n; i++) tick(1'b0, W'($urandom), a);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    sample_check();
    checks++;
    if ({m_x, m_xv, m_wd, m_busy, m_ready} !== {IDLE, 4'b0000}) begin
      errors++;
      $display("FAIL reset_state got %b want %b", {m_x, m_xv, m_wd, m_busy, m_ready}, {IDLE, 4'b0000});
    end
    rst = 1'b1;
    #1;
    sample_check();
    idle_ticks(2);
  endtask

  task automatic test_single();
    logic         a;
    logic [W-1:0] got;
    int           wd_cnt, wd_at;
    wd_cnt = 0; wd_at = -1; got = '0;
    for (int k = 1; k <= 9; k++) begin
      tick(k == 1, (k == 1) ? 8'hA5 : W'($urandom), a);
      if (k <= 8) got = {got[W-2:0], m_x};
      if (m_wd) begin wd_cnt++; wd_at = k; end
    end
    checks++;
    if (got !== 8'hA5) begin errors++; $display("FAIL single_bits got %h want a5", got); end
    checks++;
    if (wd_cnt != 1 || wd_at != 8) begin
      errors++; $display("FAIL single_word_done got count %0d at %0d want 1 at 8", wd_cnt, wd_at);
    end
    checks++;
    if ({m_x, m_xv, m_busy} !== 3'b000) begin
      errors++; $display("FAIL single_idle got %b want 000", {m_x, m_xv, m_busy});
    end
  endtask

  task automatic test_back_to_back();
    logic        a;
    logic [15:0] got;
    logic [15:0] wd_mask;
    int          vcnt;
    got = '0; wd_mask = '0; vcnt = 0;
    for (int k = 1; k <= 18; k++) begin
      tick(k <= 2, (k == 1) ? 8'hAA : (k == 2) ? 8'h0A : W'($urandom), a);
      if (k <= 16) begin
        got = {got[14:0], m_x};
        wd_mask = {wd_mask[14:0], m_wd};
        if (m_xv) vcnt++;
      end
    end
    checks++;
    if (got !== 16'hAA0A) begin errors++; $display("FAIL b2b_bits got %h want aa0a", got); end
    checks++;
    if (wd_mask !== 16'h0101) begin errors++; $display("FAIL b2b_word_done got %h want 0101", wd_mask); end
    checks++;
    if (vcnt != 16) begin errors++; $display("FAIL b2b_contiguous got %0d want 16", vcnt); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] words[3];
    int           acc_cyc[3];
    int           idx, low_cnt;
    logic         a;
    words[0] = 8'h3C; words[1] = 8'h96; words[2] = 8'hE1;
    idx = 0; low_cnt = 0;
    for (int c = 0; c <= 30; c++) begin
      if (c <= 9 && !m_ready) low_cnt++;
      tick(idx < 3, (idx < 3) ? words[idx] : W'($urandom), a);
      if (a) begin acc_cyc[idx] = c; idx++; end
    end
    checks++;
    if (idx != 3 || acc_cyc[0] != 0 || acc_cyc[1] != 1 || acc_cyc[2] != 9) begin
      errors++;
      $display("FAIL bp_accept_cycles got %0d words at %0d,%0d,%0d want 3 at 0,1,9", idx, acc_cyc[0], acc_cyc[1], acc_cyc[2]);
    end
    checks++;
    if (low_cnt != 7) begin errors++; $display("FAIL bp_ready_low got %0d want 7", low_cnt); end
  endtask

  task automatic test_lsb();
    logic         a;
    logic [W-1:0] got;
    got = '0;
    for (int k = 1; k <= 9; k++) begin
      tick(k == 1, (k == 1) ? 8'h01 : W'($urandom), a);
      if (k <= 8) got[k-1] = l_x;
    end
    checks++;
    if (got !== 8'h01) begin errors++; $display("FAIL lsb_bits got %h want 01 (bit k = cycle k+1)", got); end
  endtask

  task automatic test_reset_mid();
    logic         a;
    logic [W-1:0] w;
    tick(1'b1, 8'hFF, a);
    tick(1'b1, 8'h0F, a);
    tick(1'b0, 8'h00, a);
    tick(1'b0, 8'h00, a);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({m_xv, m_busy, m_ready, m_wd, m_x, l_xv, l_busy, l_ready} !== {4'b0000, IDLE, 3'b000}) begin
      errors++;
      $display("FAIL reset_mid_async got %b want %b", {m_xv, m_busy, m_ready, m_wd, m_x, l_xv, l_busy, l_ready}, {4'b0000, IDLE, 3'b000});
    end
    q_m.delete();
    q_l.delete();
    @(negedge clk);
    sample_check();
    @(negedge clk);
    sample_check();
    rst = 1'b1;
    #1;
    sample_check();
    w = W'($urandom) | 8'h80;
    tick(1'b1, w, a);
    checks++;
    if ({m_xv, m_x} !== 2'b11) begin
      errors++; $display("FAIL reset_mid_restart got %b want 11", {m_xv, m_x});
    end
    idle_ticks(9);
  endtask

  task automatic test_detector();
    logic a;
    hist = '0;
    for (int k = 1; k <= 9; k++) begin
      tick(k == 1, (k == 1) ? 8'hAA : W'($urandom), a);
      if (k <= 8) begin
        checks++;
        if (last_det !== (k == 4 || k == 6 || k == 8)) begin
          errors++; $display("FAIL detector_out bit %0d got %b want %b", k, last_det, (k == 4 || k == 6 || k == 8));
        end
      end
    end
  endtask

  task automatic test_random();
    logic a;
    for (int i = 0; i < 400; i++) tick($urandom_range(0, 3) != 0, W'($urandom), a);
    idle_ticks(2 * W + 4);
    checks++;
    if (q_m.size() != 0 || q_l.size() != 0) begin
      errors++; $display("FAIL random_drain got %0d/%0d bits left want 0", q_m.size(), q_l.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_lsb();
    test_reset_mid();
    test_detector();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
